// File: rtl/rr_regfile.sv
// rtl/rr_regfile.sv - register-read stage: 32-entry regfile, write-first bypass, load-use stall
module rr_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] idrr_rs,
    input  logic [ADDR_W-1:0] idrr_rt,
    input  logic              idrr_uses_rt,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rrex_memread,
    input  logic [ADDR_W-1:0] rrex_rt,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  stall_count_q;
    logic [CNT_W-1:0]  stall_count_d;
    logic              wb_commit;

    // r0 is hardwired to zero, so a write to it is dropped entirely
    assign wb_commit = wb_regwrite && (wb_rd != '0);

    // Read port with write-first bypass; r0 always reads zero
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] val;
        if (idx == '0) begin
            val = '0;
        end else if (wb_regwrite && (wb_rd == idx)) begin
            val = wb_data;
        end else begin
            val = regs_q[idx];
        end
        return val;
    endfunction

    // Next-state of the register array: at most one entry updated per cycle
    always_comb begin
        regs_d = regs_q;
        if (wb_commit) begin
            regs_d[wb_rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    // Load-use hazard and saturating stall counter next-state
    always_comb begin
        stall = rrex_memread && (rrex_rt != '0) &&
                ((rrex_rt == idrr_rs) || (idrr_uses_rt && (rrex_rt == idrr_rt)));
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Combinational read data toward the RR/EX register
    always_comb begin
        data1 = read_port(idrr_rs);
        data2 = read_port(idrr_rt);
    end

    // State registers; reset clears every entry and the counter immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_rr_regfile.sv
// tb/tb_rr_regfile.sv - directed table plus model-checked random test of rr_regfile
module tb_rr_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idrr_rs, idrr_rt, wb_rd, rrex_rt;
    logic        idrr_uses_rt, wb_regwrite, rrex_memread;
    logic [31:0] wb_data;
    logic [31:0] data1, data2, data1_b, data2_b;
    logic        stall, stall_b;
    logic [15:0] stall_count;
    logic [3:0]  stall_count_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_regs [32];
    int          exp_cnt;
    int          exp_cnt4;

    always #5 clk = ~clk;

    rr_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .idrr_rs(idrr_rs), .idrr_rt(idrr_rt), .idrr_uses_rt(idrr_uses_rt),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .rrex_memread(rrex_memread), .rrex_rt(rrex_rt),
        .data1(data1), .data2(data2), .stall(stall), .stall_count(stall_count)
    );

    rr_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .idrr_rs(idrr_rs), .idrr_rt(idrr_rt), .idrr_uses_rt(idrr_uses_rt),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .rrex_memread(rrex_memread), .rrex_rt(rrex_rt),
        .data1(data1_b), .data2(data2_b), .stall(stall_b), .stall_count(stall_count_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        use_rt;
        logic        mr;
        logic [4:0]  ert;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        es;
        logic        adv;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_stall();
        return rrex_memread && (rrex_rt != 5'd0) &&
               ((rrex_rt == idrr_rs) || (idrr_uses_rt && (rrex_rt == idrr_rt)));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_regwrite && wb_rd == idx) return wb_data;
        return ref_regs[idx];
    endfunction

    // Advance one clock: update the model with the inputs seen at the edge
    task automatic tick();
        if (reset) begin
            if (model_stall()) begin
                if (exp_cnt != 65535) exp_cnt++;
                if (exp_cnt4 != 15) exp_cnt4++;
            end
            if (wb_regwrite && wb_rd != 5'd0) ref_regs[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        exp_cnt  = 0;
        exp_cnt4 = 0;
    endtask

    task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                          input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                          input logic mr, input logic [4:0] ert);
        wb_regwrite = we; wb_rd = rd; wb_data = wd;
        idrr_rs = rs; idrr_rt = rt; idrr_uses_rt = use_rt;
        rrex_memread = mr; rrex_rt = ert;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0,        32'h12345678, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd1, 32'h0000000A, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0000000A, 32'h0,        1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd2, 32'h0000000B, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0000000A, 32'h0000000B, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd2, 32'h0,        5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0000000A, 32'h0000000B, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd7, 1'b0, 1'b1, 5'd7, 32'h0000000B, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 32'h0000000B, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'd7, 32'h00000055, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 32'h00000055, 32'h0,        1'b1, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'h00000055, 32'h00000055, 1'b0, 1'b0};

        // Power-on reset
        reset = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        model_reset();
        #1;
        check("reset_data1", data1, 32'd0);
        check("reset_count", {16'd0, stall_count}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            set_in(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].rs, vecs[i].rt,
                   vecs[i].use_rt, vecs[i].mr, vecs[i].ert);
            #1;
            check($sformatf("vec%0d_data1", i), data1, vecs[i].e1);
            check($sformatf("vec%0d_data2", i), data2, vecs[i].e2);
            check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].es});
            check($sformatf("vec%0d_count", i), {16'd0, stall_count}, exp_cnt);
            if (vecs[i].adv) tick();
        end
        check("table_count_after_stall_edge", {16'd0, stall_count}, 32'd1);

        // Mid-run asynchronous reset after writing r5
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd1, 1'b0, 1'b0, 5'd0);
        #1;
        check("r5_written", data1, 32'hDEADBEEF);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_data1", data1, 32'd0);
        check("async_reset_data2", data2, 32'd0);
        check("async_reset_count", {16'd0, stall_count}, 32'd0);
        // Writes and stalls during reset are ignored
        set_in(1'b1, 5'd5, 32'h01020304, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9);
        #1;
        check("stall_during_reset", {31'd0, stall}, 32'd1);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
        #1;
        check("write_ignored_in_reset", data1, 32'd0);
        check("count_held_in_reset", {16'd0, stall_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Three held stall cycles count 0 -> 3
        set_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("stall_cnt_%0d", k), {16'd0, stall_count}, k);
        end

        // Saturation of the 4-bit counter variant
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("sat_cnt4_%0d", k), {28'd0, stall_count_b}, exp_cnt4);
        end
        check("cnt4_saturated", {28'd0, stall_count_b}, 32'd15);
        check("cnt16_after_19", {16'd0, stall_count}, 32'd19);
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        tick();
        check("cnt4_holds", {28'd0, stall_count_b}, 32'd15);

        // Random traffic against the reference model
        for (int c = 0; c < 1000; c++) begin
            set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idrr_rs = wb_rd;
            if ($urandom_range(0, 3) == 0) rrex_rt = idrr_rt;
            #1;
            check("rnd_data1", data1, model_read(idrr_rs));
            check("rnd_data2", data2, model_read(idrr_rt));
            check("rnd_stall", {31'd0, stall}, {31'd0, model_stall()});
            check("rnd_count", {16'd0, stall_count}, exp_cnt);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_regfile.md
Name: rr_regfile

Overview:
- Register-read stage of the 6-stage pipeline: the source that produces data1/data2 for the RR/EX pipeline register.
- Holds the 32-entry architectural register file and accepts the write-back port from WB.
- Provides write-first bypass so RR sees same-cycle WB results.
- Detects load-use hazards against the instruction currently in EX and raises a stall toward the IF/ID and ID/RR registers.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register index width (2**ADDR_W entries)
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
idrr_rs  input  ADDR_W  source register 1 index of instruction in RR
idrr_rt  input  ADDR_W  source register 2 index of instruction in RR
idrr_uses_rt  input  1  1 = instruction reads rt as a source (R-type, store, branch)
wb_regwrite  input  1  write-back enable
wb_rd  input  ADDR_W  write-back destination index
wb_data  input  DATA_W  write-back data
rrex_memread  input  1  instruction now in EX is a load
rrex_rt  input  ADDR_W  load destination of instruction now in EX
data1  output  DATA_W  read data for rs, to RR/EX register
data2  output  DATA_W  read data for rt, to RR/EX register
stall  output  1  load-use hazard: hold PC, IF/ID and ID/RR; insert bubble into RR/EX
stall_count  output  CNT_W  saturating count of stall cycles since reset

Behaviour:
- Storage: 2**ADDR_W entries x DATA_W. Entry 0 reads as 0 always and is never written.
- Reset (reset==0, asynchronous):
  - all entries and stall_count cleared to 0 immediately, with no clock edge required;
  - data1/data2 then read 0; stall follows its inputs (combinational);
  - while reset is low, writes are ignored and the counter holds at 0;
  - reset deassertion takes effect at the next rising edge.
- Write: at the rising edge when wb_regwrite==1 and wb_rd!=0, entry[wb_rd] <= wb_data. wb_rd==0 is a no-op.
- Read: combinational, zero latency.
  - data1 = 0 if idrr_rs==0;
  - else wb_data if wb_regwrite==1 and wb_rd==idrr_rs (write-first bypass);
  - else entry[idrr_rs].
  - data2 is identical using idrr_rt.
  - The bypass is evaluated regardless of idrr_uses_rt.
- Hazard: stall = rrex_memread & (rrex_rt!=0) & ((rrex_rt==idrr_rs) | (idrr_uses_rt & (rrex_rt==idrr_rt))).
  - Combinational, with no register on the path.
  - A single load produces exactly one stall cycle. The upstream bubble clears rrex_memread on the next cycle, so stall drops by itself.
- stall_count:
  - at each rising edge out of reset, if stall==1 and stall_count != all-ones, increment by 1;
  - at all-ones it holds (saturates, no wrap).
- Simultaneous events:
  - a WB write plus an RR read of the same index in one cycle returns the new data, and the entry is updated at that edge;
  - a WB write plus an asserted stall are independent: the write still commits.
- No X propagation: every output is defined for all inputs once reset has been applied.

Test Plan:
1. Assert reset low mid-run after writing r5=0xDEADBEEF -> data1 with idrr_rs=5 reads 0 before the next clk edge; stall_count=0.
2. Write wb_rd=3, wb_data=0x12345678 while idrr_rs=3, idrr_rt=3 -> data1=data2=0x12345678 in the same cycle (bypass); after the edge with wb_regwrite=0, still 0x12345678.
3. wb_regwrite=1, wb_rd=0, wb_data=0xFFFFFFFF, idrr_rs=0 -> data1=0 both before and after the edge.
4. rrex_memread=1, rrex_rt=7, idrr_rs=7 -> stall=1. Then idrr_rs=2, idrr_rt=7, idrr_uses_rt=0 -> stall=0. Then idrr_uses_rt=1 -> stall=1. Then rrex_rt=0 -> stall=0.
5. Hold the stall condition for 3 cycles -> stall_count goes 0→3. Preload near saturation (CNT_W=4 variant, 16 stall cycles) -> count stops at 15 and holds.
6. Back-to-back writes r1=0xA, r2=0xB, then read idrr_rs=1, idrr_rt=2 with wb_regwrite=0 -> data1=0xA, data2=0xB; random write/read sequence cross-checked against a reference model for 1000 cycles.
